range_copy_engine: RTL and testbench

Parametrised register-array copy engine. It holds a DEPTH x WIDTH array and, on command, walks indices 0..DEPTH-1 one per cycle. At each index i it evaluates a compound range condition, (i >= lo) && (i <= hi), and writes a snapshot of mem[src] into each qualifying entry. Two modes are supported: WHILE mode stops at the first false condition, like a for-loop with a compound test; FILTER mode skips false indices and continues. It sits beside the unroll/loop regression blocks as the sequential, run-time equivalent of a for-loop with a complex condition.

---
 rtl/range_copy_pkg.sv | 15 +
 rtl/range_copy_mem.sv | 38 +++
 rtl/range_copy_engine.sv | 125 ++++++++++++
 tb/tb_range_copy_engine.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/range_copy_pkg.sv
// rtl/range_copy_pkg.sv - shared mode and state encodings for the range copy engine
package range_copy_pkg;

    typedef enum logic {
        MODE_WHILE  = 1'b0,
        MODE_FILTER = 1'b1
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/range_copy_mem.sv
// rtl/range_copy_mem.sv - DEPTH x WIDTH register array with one write port and two read ports
module range_copy_mem #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic [AW-1:0]    snap_addr,
    output logic [WIDTH-1:0] snap_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Non-power-of-two depths leave index codes with no backing entry.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < (AW+1)'(DEPTH);
    endfunction

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem[k] <= '0;
            end
        end else if (we && in_range(waddr)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rd_data   = in_range(rd_addr)   ? mem[rd_addr]   : '0;
    assign snap_data = in_range(snap_addr) ? mem[snap_addr] : '0;

endmodule

// File: rtl/range_copy_engine.sv
// rtl/range_copy_engine.sv - walks the array copying a source snapshot into entries within [lo,hi]
module range_copy_engine
    import range_copy_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_l,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [AW-1:0]    cmd_lo,
    input  logic [AW-1:0]    cmd_hi,
    input  logic [AW-1:0]    cmd_src,
    input  logic             cmd_mode,
    output logic             busy,
    output logic             done,
    output logic [AW:0]      count,
    output logic             wr_drop
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_e           state;
    mode_e            mode_q;
    logic [AW-1:0]    idx;
    logic [AW-1:0]    lo_q;
    logic [AW-1:0]    hi_q;
    logic [WIDTH-1:0] src_val;
    logic [WIDTH-1:0] snap_data;
    logic             cond;
    logic             eng_we;
    logic             mem_we;
    logic [AW-1:0]    mem_waddr;
    logic [WIDTH-1:0] mem_wdata;

    assign cond   = (idx >= lo_q) && (idx <= hi_q);
    assign eng_we = (state == ST_SCAN) && cond;

    // Host and engine never contend: the host port is only open while idle.
    assign mem_we    = eng_we || (wr_en && !busy);
    assign mem_waddr = eng_we ? idx     : wr_addr;
    assign mem_wdata = eng_we ? src_val : wr_data;

    range_copy_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk       (clk),
        .reset_l   (reset_l),
        .we        (mem_we),
        .waddr     (mem_waddr),
        .wdata     (mem_wdata),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .snap_addr (cmd_src),
        .snap_data (snap_data)
    );

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state     <= ST_IDLE;
            mode_q    <= MODE_WHILE;
            idx       <= '0;
            lo_q      <= '0;
            hi_q      <= '0;
            src_val   <= '0;
            cmd_ready <= 1'b1;
            busy      <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            wr_drop   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (wr_en && busy) begin
                wr_drop <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        lo_q      <= cmd_lo;
                        hi_q      <= cmd_hi;
                        mode_q    <= mode_e'(cmd_mode);
                        src_val   <= snap_data;
                        idx       <= '0;
                        count     <= '0;
                        wr_drop   <= 1'b0;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        state     <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (cond) begin
                        count <= count + 1'b1;
                    end
                    if ((!cond && mode_q == MODE_WHILE) || idx == LAST) begin
                        done  <= 1'b1;
                        state <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
                default: begin
                    cmd_ready <= 1'b1;
                    busy      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_copy_engine.sv
// tb/tb_range_copy_engine.sv - table, directed and randomized checks of range_copy_engine
module tb_range_copy_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // 4 x 4 instance
    logic        a_rst, a_wr_en, a_cmd_valid, a_cmd_ready, a_mode, a_busy, a_done, a_wr_drop;
    logic [1:0]  a_wr_addr, a_rd_addr, a_lo, a_hi, a_src;
    logic [3:0]  a_wr_data, a_rd_data;
    logic [2:0]  a_count;

    // 8 x 16 instance
    logic        b_rst, b_wr_en, b_cmd_valid, b_cmd_ready, b_mode, b_busy, b_done, b_wr_drop;
    logic [2:0]  b_wr_addr, b_rd_addr, b_lo, b_hi, b_src;
    logic [15:0] b_wr_data, b_rd_data;
    logic [3:0]  b_count;

    range_copy_engine #(.WIDTH(4), .DEPTH(4)) dut_a (
        .clk(clk), .reset_l(a_rst), .wr_en(a_wr_en), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
        .rd_addr(a_rd_addr), .rd_data(a_rd_data), .cmd_valid(a_cmd_valid), .cmd_ready(a_cmd_ready),
        .cmd_lo(a_lo), .cmd_hi(a_hi), .cmd_src(a_src), .cmd_mode(a_mode), .busy(a_busy),
        .done(a_done), .count(a_count), .wr_drop(a_wr_drop)
    );

    range_copy_engine #(.WIDTH(16), .DEPTH(8)) dut_b (
        .clk(clk), .reset_l(b_rst), .wr_en(b_wr_en), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
        .rd_addr(b_rd_addr), .rd_data(b_rd_data), .cmd_valid(b_cmd_valid), .cmd_ready(b_cmd_ready),
        .cmd_lo(b_lo), .cmd_hi(b_hi), .cmd_src(b_src), .cmd_mode(b_mode), .busy(b_busy),
        .done(b_done), .count(b_count), .wr_drop(b_wr_drop)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0][3:0] init;
        int              lo;
        int              hi;
        int              src;
        int              mode;
        int              exp_n;
        int              exp_cnt;
        logic [3:0][3:0] exp_mem;
    } vec_t;

    vec_t vecs[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: the loop the engine stands in for, evaluated directly.
    function automatic void model(inout logic [3:0][3:0] m, input int lo, input int hi,
                                  input int src, input int mode, output int n, output int cnt);
        logic [3:0] sv;
        sv  = m[src];
        n   = 0;
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            n++;
            if (i >= lo && i <= hi) begin
                m[i] = sv;
                cnt++;
            end else if (mode == 0) begin
                break;
            end
        end
    endfunction

    task automatic host_write(input int addr, input logic [3:0] data);
        @(negedge clk);
        a_wr_en   = 1'b1;
        a_wr_addr = addr[1:0];
        a_wr_data = data;
        @(negedge clk);
        a_wr_en   = 1'b0;
    endtask

    task automatic load(input logic [3:0][3:0] v);
        for (int k = 0; k < 4; k++) host_write(k, v[k]);
    endtask

    task automatic check_mem(input string tag, input logic [3:0][3:0] exp);
        for (int k = 0; k < 4; k++) begin
            a_rd_addr = k[1:0];
            #1;
            chk(tag, a_rd_data, exp[k]);
        end
    endtask

    task automatic start_cmd(input int lo, input int hi, input int src, input int mode);
        @(negedge clk);
        a_lo = lo[1:0];
        a_hi = hi[1:0];
        a_src = src[1:0];
        a_mode = mode[0];
        a_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        a_cmd_valid = 1'b0;
        chk("ready_low", a_cmd_ready, 0);
        chk("busy_high", a_busy, 1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!a_done && n < 64);
        if (!a_done) chk("done_timeout", 0, 1);
        @(posedge clk);
        #1;
        chk("done_pulse", a_done, 0);
        chk("ready_back", a_cmd_ready, 1);
        chk("busy_back", a_busy, 0);
    endtask

    task automatic run_cmd(input string tag, input int lo, input int hi, input int src, input int mode,
                           input int exp_n, input int exp_cnt, input logic [3:0][3:0] exp_mem);
        int n;
        start_cmd(lo, hi, src, mode);
        wait_done(n);
        chk({tag, "_n"}, n, exp_n);
        chk({tag, "_count"}, a_count, exp_cnt);
        check_mem({tag, "_mem"}, exp_mem);
    endtask

    initial begin
        int n, cnt, lo, hi, src, mode;
        logic [3:0][3:0] m0, m1;

        vecs[0] = '{16'h3210, 2, 3, 0, 0, 1, 0, 16'h3210};
        vecs[1] = '{16'h3210, 2, 3, 0, 1, 4, 2, 16'h0010};
        vecs[2] = '{16'h8765, 0, 2, 2, 0, 4, 3, 16'h8777};
        vecs[3] = '{16'h3210, 3, 1, 0, 1, 4, 0, 16'h3210};
        vecs[4] = '{16'h3210, 3, 1, 0, 0, 1, 0, 16'h3210};
        vecs[5] = '{16'h4321, 1, 3, 3, 1, 4, 3, 16'h4441};
        vecs[6] = '{16'hdcba, 0, 3, 1, 0, 4, 4, 16'hbbbb};

        a_rst = 1'b0; a_wr_en = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        a_cmd_valid = 1'b0; a_lo = '0; a_hi = '0; a_src = '0; a_mode = 1'b0;
        b_rst = 1'b0; b_wr_en = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        b_cmd_valid = 1'b0; b_lo = '0; b_hi = '0; b_src = '0; b_mode = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        a_rst = 1'b1;
        b_rst = 1'b1;
        #1;
        chk("rst_ready", a_cmd_ready, 1);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_count", a_count, 0);
        chk("rst_drop", a_wr_drop, 0);
        check_mem("rst_mem", 16'h0000);

        for (int v = 0; v < 7; v++) begin
            load(vecs[v].init);
            run_cmd($sformatf("vec%0d", v), vecs[v].lo, vecs[v].hi, vecs[v].src, vecs[v].mode,
                    vecs[v].exp_n, vecs[v].exp_cnt, vecs[v].exp_mem);
        end

        // Host write and second command during a scan are both dropped.
        load(16'h3210);
        start_cmd(0, 3, 2, 1);
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 2'd1; a_wr_data = 4'h9;
        a_lo = 2'd0; a_hi = 2'd0; a_src = 2'd0; a_mode = 1'b0; a_cmd_valid = 1'b1;
        @(negedge clk);
        a_wr_en = 1'b0;
        a_cmd_valid = 1'b0;
        wait_done(n);
        chk("busy_n", n, 3);
        chk("busy_count", a_count, 4);
        chk("busy_drop", a_wr_drop, 1);
        repeat (3) @(negedge clk);
        chk("no_queue", a_busy, 0);
        chk("drop_hold", a_wr_drop, 1);
        check_mem("busy_mem", 16'h2222);

        // Host write coinciding with accept lands, snapshot sees the old value.
        load(16'h3210);
        @(negedge clk);
        a_wr_en = 1'b1; a_wr_addr = 2'd0; a_wr_data = 4'h9;
        a_lo = 2'd1; a_hi = 2'd2; a_src = 2'd0; a_mode = 1'b1; a_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        a_wr_en = 1'b0;
        a_cmd_valid = 1'b0;
        chk("drop_clear", a_wr_drop, 0);
        wait_done(n);
        chk("acc_n", n, 4);
        chk("acc_count", a_count, 2);
        check_mem("acc_mem", 16'h3009);

        for (int r = 0; r < 40; r++) begin
            m0   = 16'($urandom);
            lo   = $urandom_range(0, 3);
            hi   = $urandom_range(0, 3);
            src  = $urandom_range(0, 3);
            mode = $urandom_range(0, 1);
            m1   = m0;
            model(m1, lo, hi, src, mode, n, cnt);
            load(m0);
            run_cmd($sformatf("rnd%0d", r), lo, hi, src, mode, n, cnt, m1);
        end

        // Reset in the middle of a scan on the wider instance.
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            b_wr_en = 1'b1; b_wr_addr = k[2:0]; b_wr_data = 16'h0100 + 16'(k);
        end
        @(negedge clk);
        b_wr_en = 1'b0;
        b_lo = 3'd0; b_hi = 3'd7; b_src = 3'd3; b_mode = 1'b1; b_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        b_rst = 1'b0;
        #1;
        chk("mid_busy", b_busy, 0);
        chk("mid_done", b_done, 0);
        chk("mid_count", b_count, 0);
        chk("mid_drop", b_wr_drop, 0);
        for (int k = 0; k < 8; k++) begin
            b_rd_addr = k[2:0];
            #1;
            chk("mid_mem", b_rd_data, 0);
        end
        @(negedge clk);
        b_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("mid_ready", b_cmd_ready, 1);
        @(negedge clk);
        b_wr_en = 1'b1; b_wr_addr = 3'd5; b_wr_data = 16'hbeef;
        @(negedge clk);
        b_wr_en = 1'b0;
        b_lo = 3'd0; b_hi = 3'd7; b_src = 3'd5; b_mode = 1'b1; b_cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        b_cmd_valid = 1'b0;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!b_done && n < 64);
        chk("b_n", n, 8);
        chk("b_count", b_count, 8);
        for (int k = 0; k < 8; k++) begin
            b_rd_addr = k[2:0];
            #1;
            chk("b_mem", b_rd_data, 16'hbeef);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
